param_sync_fifo: RTL and testbench

// Parametrised single-clock FIFO; next generation of the fixed 16x16 FIFO. Adds configurable

---
 rtl/param_sync_fifo_if.sv | 34 +++
 rtl/param_sync_fifo.sv | 93 +++++++++
 tb/tb_param_sync_fifo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/param_sync_fifo_if.sv
// Handshake bundle for param_sync_fifo: write/read requests, data,
// occupancy and status flags. master = producer/consumer, slave = FIFO.
interface param_sync_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             fifo_write;
  logic             fifo_read;
  logic [WIDTH-1:0] fifo_data_in;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_almost_full;
  logic             fifo_almost_empty;
  logic [AW:0]      fifo_count;
  logic             fifo_overflow;
  logic             fifo_underflow;

  modport master (
    output fifo_write, fifo_read, fifo_data_in,
    input  fifo_data_out, fifo_full, fifo_empty,
    input  fifo_almost_full, fifo_almost_empty,
    input  fifo_count, fifo_overflow, fifo_underflow
  );

  modport slave (
    input  fifo_write, fifo_read, fifo_data_in,
    output fifo_data_out, fifo_full, fifo_empty,
    output fifo_almost_full, fifo_almost_empty,
    output fifo_count, fifo_overflow, fifo_underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with registered count/flags and
// overflow/underflow pulses. Ports: clk, rst (sync, active-high),
// bus (param_sync_fifo_if.slave). Define FIFO_FWFT_EN for
// first-word-fall-through reads; default is registered read data.
module param_sync_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input logic clk,
  input logic rst,
  param_sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C   = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C   = (AW+1)'(AE_THRESH);
  localparam logic [AW:0] ONE_C  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nx;
  logic             full;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;

  // Acceptance uses the registered flags only, so a full FIFO
  // still takes a read and an empty one still takes a write.
  assign wr_ok = bus.fifo_write && !full;
  assign rd_ok = bus.fifo_read && !empty;

  always_comb begin
    count_nx = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nx = count + ONE_C;
      2'b01:   count_nx = count - ONE_C;
      default: count_nx = count;
    endcase
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.fifo_data_in;
  end

  // Flags are derived from the next count so they line up with
  // fifo_count one cycle after the causing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      count                 <= '0;
      full                  <= 1'b0;
      empty                 <= 1'b1;
      bus.fifo_almost_full  <= 1'b0;
      bus.fifo_almost_empty <= 1'b1;
      bus.fifo_overflow     <= 1'b0;
      bus.fifo_underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count                 <= count_nx;
      full                  <= (count_nx == FULL_C);
      empty                 <= (count_nx == '0);
      bus.fifo_almost_full  <= (count_nx >= AF_C);
      bus.fifo_almost_empty <= (count_nx <= AE_C);
      bus.fifo_overflow     <= bus.fifo_write && full;
      bus.fifo_underflow    <= bus.fifo_read && empty;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word shown directly; zero while empty.
  assign bus.fifo_data_out = empty ? '0 : mem[rd_ptr];
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst)        dout_q <= '0;
    else if (rd_ok) dout_q <= mem[rd_ptr];
  end

  assign bus.fifo_data_out = dout_q;
`endif

  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised + directed bench for param_sync_fifo against a
// queue-based model of the FIFO rules.
module tb_param_sync_fifo;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  param_sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_sync_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_ov = 1'b0;
  logic             m_un = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(bus.fifo_count), 32'(n));
    chk("empty", 32'(bus.fifo_empty), 32'(n == 0));
    chk("full", 32'(bus.fifo_full), 32'(n == DEPTH));
    chk("afull", 32'(bus.fifo_almost_full), 32'(n >= AF));
    chk("aempty", 32'(bus.fifo_almost_empty), 32'(n <= AE));
    chk("overflow", 32'(bus.fifo_overflow), 32'(m_ov));
    chk("underflow", 32'(bus.fifo_underflow), 32'(m_un));
`ifdef FIFO_FWFT_EN
    chk("dout", 32'(bus.fifo_data_out), 32'(n > 0 ? q[0] : '0));
`else
    chk("dout", 32'(bus.fifo_data_out), 32'(m_dout));
`endif
  endtask

  // One clock: drive, update the model on the edge, check after.
  task automatic step(input logic w, input logic r,
                      input logic [WIDTH-1:0] d, input logic rs);
    int n;
    logic [WIDTH-1:0] head;
    bus.fifo_write   = w;
    bus.fifo_read    = r;
    bus.fifo_data_in = d;
    rst              = rs;
    @(posedge clk);
    n = q.size();
    if (rs) begin
      q.delete();
      m_dout = '0;
      m_ov   = 1'b0;
      m_un   = 1'b0;
    end else begin
      m_ov = w && (n == DEPTH);
      m_un = r && (n == 0);
      if (r && n > 0) begin
        head   = q.pop_front();
        m_dout = head;
      end
      if (w && n < DEPTH) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] w3[3];
    bus.fifo_write   = 1'b0;
    bus.fifo_read    = 1'b0;
    bus.fifo_data_in = '0;
    w3[0] = 16'h18E9;
    w3[1] = 16'h1234;
    w3[2] = 16'hA9BA;

    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    for (int i = 0; i < 3; i++) step(1, 0, w3[i], 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(0, 0, '0, 0);
    step(0, 1, '0, 0);

    for (int i = 0; i < 17; i++) step(1, 0, WIDTH'(16'h0100 + i), 0);
    step(0, 0, '0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, '0, 0);
    step(0, 0, '0, 0);

    for (int i = 0; i < 8; i++) step(1, 0, WIDTH'(16'h2000 + i), 0);
    for (int i = 0; i < 40; i++) step(1, 1, WIDTH'(16'h3000 + i), 0);
    for (int i = 0; i < 8; i++) step(1, 0, WIDTH'(16'h4000 + i), 0);
    step(1, 1, 16'hBEEF, 0);
    step(1, 1, 16'hCAFE, 0);
    for (int i = 0; i < 17; i++) step(0, 1, '0, 0);
    step(1, 1, 16'h7777, 0);
    step(0, 0, '0, 0);
    step(1, 1, 16'h8888, 0);

    while (q.size() < 5) step(1, 0, WIDTH'($urandom), 0);
    while (q.size() > 5) step(0, 1, '0, 0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    step(1, 0, 16'h0055, 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);

    for (int i = 0; i < 3000; i++) begin
      v = WIDTH'($urandom);
      if (i % 500 < 250)
        step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
             v, $urandom_range(0, 299) == 0);
      else
        step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 7,
             v, $urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
